// File: rtl/fwd_pkg.sv
// Shared entry type, default widths and stage index type for the forwarding scoreboard.
package fwd_pkg;

   localparam int FWD_DATA_W = 128;
   localparam int FWD_ADDR_W = 7;
   localparam int FWD_DEPTH  = 7;
   localparam int FWD_STG_W  = $clog2(FWD_DEPTH + 1);

   typedef logic [FWD_STG_W-1:0] fwd_stage_t;

   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic [FWD_ADDR_W-1:0] rt;
      logic [FWD_DATA_W-1:0] data;
   } fwd_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// One operand read port: combinational priority select over the flattened entry array.
// Entry 0 is the highest-priority (newest) candidate.
module fwd_lookup
   import fwd_pkg::*;
#(
   parameter int  NUM_ENT = 14,
   parameter int  DATA_W  = FWD_DATA_W,
   parameter int  ADDR_W  = FWD_ADDR_W,
   parameter type entry_t = fwd_entry_t
) (
   input  entry_t [NUM_ENT-1:0] entries,
   input  logic   [ADDR_W-1:0]  addr,
   input  logic   [DATA_W-1:0]  rf_data,
   output logic   [DATA_W-1:0]  data,
   output logic                 fwd,
   output logic                 pending
);

   logic              hit;
   logic              hit_ready;
   logic [DATA_W-1:0] hit_data;

   // Walk from lowest to highest priority so the newest match overwrites older ones.
   always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
         if (entries[i].valid && entries[i].rt == addr) begin
            hit       = 1'b1;
            hit_ready = entries[i].ready;
            hit_data  = entries[i].data;
         end
      end
   end

   assign fwd     = hit & hit_ready;
   assign pending = hit & ~hit_ready;
   assign data    = fwd ? hit_data : rf_data;

endmodule

// File: rtl/fwd_scoreboard.sv
// Multi-pipe forwarding scoreboard: tracks in-flight results, forwards operands, stalls, writes back.
// Optional build macro FWD_STATS_EN adds saturating forward-hit and stall counters.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_PIPES = 2,
   parameter int DEPTH     = FWD_DEPTH,
   parameter int DATA_W    = FWD_DATA_W,
   parameter int ADDR_W    = FWD_ADDR_W,
   parameter int NUM_RD    = 5,
   parameter int STG_W     = $clog2(DEPTH + 1)
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               hold,
   input  logic [NUM_PIPES-1:0]               issue_valid,
   input  logic [NUM_PIPES-1:0][ADDR_W-1:0]   issue_rt,
   input  logic [NUM_PIPES-1:0]               res_valid,
   input  logic [NUM_PIPES-1:0][STG_W-1:0]    res_stage,
   input  logic [NUM_PIPES-1:0][DATA_W-1:0]   res_data,
   input  logic                               flush_valid,
   input  logic [STG_W-1:0]                   flush_stage,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]      rd_addr,
   input  logic [NUM_RD-1:0][DATA_W-1:0]      rd_rf_data,
   output logic [NUM_RD-1:0][DATA_W-1:0]      rd_data,
   output logic [NUM_RD-1:0]                  rd_fwd,
   output logic                               stall,
   output logic [NUM_PIPES-1:0]               wb_valid,
   output logic [NUM_PIPES-1:0][ADDR_W-1:0]   wb_addr,
   output logic [NUM_PIPES-1:0][DATA_W-1:0]   wb_data,
   output logic                               err_late
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]                        fwd_hit_cnt,
   output logic [31:0]                        stall_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [ADDR_W-1:0] rt;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Issue and result inputs are single-cycle pulses with no backpressure; stall is the only throttle.
   entry_t [DEPTH-1:0][NUM_PIPES-1:0] ent_q;
   entry_t [DEPTH-1:0][NUM_PIPES-1:0] ent_d;
   entry_t [DEPTH*NUM_PIPES-1:0]      ent_prio;
   logic   [NUM_RD-1:0]               rd_pending;
   logic                              late;

   always_comb begin
      ent_d = ent_q;
      for (int p = 0; p < NUM_PIPES; p++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (res_valid[p] && res_stage[p] == STG_W'(s + 1) && ent_d[s][p].valid) begin
               ent_d[s][p].ready = 1'b1;
               ent_d[s][p].data  = res_data[p];
            end
         end
      end
      for (int s = 0; s < DEPTH; s++) begin
         if (flush_valid && STG_W'(s + 1) < flush_stage) begin
            for (int p = 0; p < NUM_PIPES; p++) ent_d[s][p].valid = 1'b0;
         end
      end
      if (!hold) begin
         for (int s = DEPTH - 1; s > 0; s--) ent_d[s] = ent_d[s-1];
         for (int p = 0; p < NUM_PIPES; p++) begin
            ent_d[0][p]       = '0;
            ent_d[0][p].valid = issue_valid[p] & ~flush_valid;
            ent_d[0][p].rt    = issue_rt[p];
         end
      end
   end

   always_comb begin
      late = 1'b0;
      for (int p = 0; p < NUM_PIPES; p++)
         late = late | (ent_q[DEPTH-1][p].valid & ~ent_q[DEPTH-1][p].ready);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ent_q    <= '0;
         err_late <= 1'b0;
      end else begin
         ent_q <= ent_d;
         if (late) err_late <= 1'b1;
      end
   end

   // Flatten so lower stage first, higher pipe first within a stage, lands at lower index.
   always_comb begin
      for (int s = 0; s < DEPTH; s++)
         for (int p = 0; p < NUM_PIPES; p++)
            ent_prio[s*NUM_PIPES + (NUM_PIPES - 1 - p)] = ent_q[s][p];
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      fwd_lookup #(
         .NUM_ENT (DEPTH * NUM_PIPES),
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .entry_t (entry_t)
      ) u_lookup (
         .entries (ent_prio),
         .addr    (rd_addr[r]),
         .rf_data (rd_rf_data[r]),
         .data    (rd_data[r]),
         .fwd     (rd_fwd[r]),
         .pending (rd_pending[r])
      );
   end

   assign stall = |rd_pending;

   always_comb begin
      for (int p = 0; p < NUM_PIPES; p++) begin
         wb_valid[p] = ent_q[DEPTH-1][p].valid & ent_q[DEPTH-1][p].ready & ~hold;
         wb_addr[p]  = ent_q[DEPTH-1][p].rt;
         wb_data[p]  = ent_q[DEPTH-1][p].data;
      end
   end

`ifdef FWD_STATS_EN
   localparam int CNT_W = $clog2(NUM_RD + 1);
   logic [CNT_W-1:0] hit_num;
   logic [32:0]      hit_sum;

   always_comb begin
      hit_num = '0;
      for (int r = 0; r < NUM_RD; r++) hit_num = hit_num + CNT_W'(rd_fwd[r]);
      hit_sum = {1'b0, fwd_hit_cnt} + 33'(hit_num);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fwd_hit_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         fwd_hit_cnt <= hit_sum[32] ? '1 : hit_sum[31:0];
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios followed by randomized traffic,
// all compared against an in-flight instruction list model.
`timescale 1ns/1ps
module tb_fwd_scoreboard;

   localparam int NP    = 2;
   localparam int DEPTH = 7;
   localparam int DW    = 128;
   localparam int AW    = 7;
   localparam int NR    = 5;
   localparam int SW    = 3;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    hold;
   logic [NP-1:0]           issue_valid;
   logic [NP-1:0][AW-1:0]   issue_rt;
   logic [NP-1:0]           res_valid;
   logic [NP-1:0][SW-1:0]   res_stage;
   logic [NP-1:0][DW-1:0]   res_data;
   logic                    flush_valid;
   logic [SW-1:0]           flush_stage;
   logic [NR-1:0][AW-1:0]   rd_addr;
   logic [NR-1:0][DW-1:0]   rd_rf_data;
   logic [NR-1:0][DW-1:0]   rd_data;
   logic [NR-1:0]           rd_fwd;
   logic                    stall;
   logic [NP-1:0]           wb_valid;
   logic [NP-1:0][AW-1:0]   wb_addr;
   logic [NP-1:0][DW-1:0]   wb_data;
   logic                    err_late;
`ifdef FWD_STATS_EN
   logic [31:0]             fwd_hit_cnt;
   logic [31:0]             stall_cnt;
`endif

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   fwd_scoreboard #(
      .NUM_PIPES (NP), .DEPTH (DEPTH), .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .STG_W (SW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .hold        (hold),
      .issue_valid (issue_valid),
      .issue_rt    (issue_rt),
      .res_valid   (res_valid),
      .res_stage   (res_stage),
      .res_data    (res_data),
      .flush_valid (flush_valid),
      .flush_stage (flush_stage),
      .rd_addr     (rd_addr),
      .rd_rf_data  (rd_rf_data),
      .rd_data     (rd_data),
      .rd_fwd      (rd_fwd),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .err_late    (err_late)
`ifdef FWD_STATS_EN
      ,
      .fwd_hit_cnt (fwd_hit_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   // ---------------- reference model: list of in-flight instructions ----------------
   typedef struct {
      int            pipe;
      int            stage;
      logic [AW-1:0] rt;
      logic          ready;
      logic [DW-1:0] data;
   } inst_t;

   inst_t mq[$];
   bit    m_err;
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      logic          exp_stall;
      logic          exp_fwd;
      logic [DW-1:0] exp_data;
      logic          exp_wb;
      int            best;
      int            w;
      exp_stall = 1'b0;
      for (int r = 0; r < NR; r++) begin
         best = -1;
         foreach (mq[i]) begin
            if (mq[i].rt == rd_addr[r]) begin
               if (best < 0 || mq[i].stage < mq[best].stage ||
                   (mq[i].stage == mq[best].stage && mq[i].pipe > mq[best].pipe))
                  best = i;
            end
         end
         exp_fwd  = 1'b0;
         exp_data = rd_rf_data[r];
         if (best >= 0) begin
            if (mq[best].ready) begin
               exp_fwd  = 1'b1;
               exp_data = mq[best].data;
            end else begin
               exp_stall = 1'b1;
            end
         end
         chk($sformatf("rd_data[%0d]", r), rd_data[r], exp_data);
         chk($sformatf("rd_fwd[%0d]", r), rd_fwd[r], exp_fwd);
      end
      chk("stall", stall, exp_stall);
      for (int p = 0; p < NP; p++) begin
         w = -1;
         foreach (mq[i]) if (mq[i].stage == DEPTH && mq[i].pipe == p) w = i;
         exp_wb = (w >= 0) && mq[w].ready && !hold;
         chk($sformatf("wb_valid[%0d]", p), wb_valid[p], exp_wb);
         if (exp_wb) begin
            chk($sformatf("wb_addr[%0d]", p), wb_addr[p], mq[w].rt);
            chk($sformatf("wb_data[%0d]", p), wb_data[p], mq[w].data);
         end
      end
      chk("err_late", err_late, m_err);
   endtask

   task automatic model_edge();
      inst_t n;
      foreach (mq[i]) if (mq[i].stage == DEPTH && !mq[i].ready) m_err = 1'b1;
      for (int p = 0; p < NP; p++) begin
         if (res_valid[p]) begin
            foreach (mq[i]) begin
               if (mq[i].pipe == p && mq[i].stage == int'(res_stage[p])) begin
                  mq[i].ready = 1'b1;
                  mq[i].data  = res_data[p];
               end
            end
         end
      end
      if (flush_valid)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].stage < int'(flush_stage)) mq.delete(i);
      if (!hold) begin
         foreach (mq[i]) mq[i].stage++;
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].stage > DEPTH) mq.delete(i);
         if (!flush_valid) begin
            for (int p = 0; p < NP; p++) begin
               if (issue_valid[p]) begin
                  n.pipe  = p;
                  n.stage = 1;
                  n.rt    = issue_rt[p];
                  n.ready = 1'b0;
                  n.data  = '0;
                  mq.push_back(n);
               end
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      hold        = 1'b0;
      issue_valid = '0;
      issue_rt    = '0;
      res_valid   = '0;
      res_stage   = '0;
      res_data    = '0;
      flush_valid = 1'b0;
      flush_stage = '0;
      rd_addr     = '0;
      for (int r = 0; r < NR; r++) rd_rf_data[r] = DW'(32'hF00 + r);
   endtask

   task automatic issue(input int p, input logic [AW-1:0] rt);
      issue_valid[p] = 1'b1;
      issue_rt[p]    = rt;
   endtask

   task automatic result(input int p, input logic [SW-1:0] stg, input logic [DW-1:0] d);
      res_valid[p] = 1'b1;
      res_stage[p] = stg;
      res_data[p]  = d;
   endtask

   // Called at a falling edge with inputs set: check, clock, advance the model.
   task automatic step();
      #1 check_outputs();
      @(posedge clock);
      #1 model_edge();
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      mq.delete();
      m_err = 1'b0;
      chk("rst_err_late", err_late, 1'b0);
      chk("rst_wb_valid", wb_valid, '0);
      check_outputs();
      @(posedge clock);
      #1 check_outputs();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random stimulus ----------------
   initial begin
      reset = 1'b1;
      m_err = 1'b0;
      idle();
      #1 check_outputs();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // basic forward
      idle(); issue(0, 7'd1); step();
      idle(); step();
      idle(); result(0, 3'd2, 128'd2); rd_addr[0] = 7'd1; #1 chk("basic_stall", stall, 1'b1); step();
      idle(); rd_addr[0] = 7'd1;
      #1 chk("basic_fwd_data", rd_data[0], 128'd2); chk("basic_fwd_flag", rd_fwd[0], 1'b1); step();
      repeat (3) begin idle(); step(); end
      idle();
      #1 chk("basic_wb_valid", wb_valid[0], 1'b1); chk("basic_wb_addr", wb_addr[0], 7'd1);
      chk("basic_wb_data", wb_data[0], 128'd2); step();

      // newest wins
      idle(); issue(0, 7'd4); step();
      idle(); result(0, 3'd1, 128'd1); step();
      idle(); step();
      idle(); issue(0, 7'd4); rd_addr[1] = 7'd4; #1 chk("newest_old", rd_data[1], 128'd1); step();
      idle(); rd_addr[1] = 7'd4; result(0, 3'd1, 128'd6);
      #1 chk("newest_stall", stall, 1'b1); chk("newest_rf", rd_data[1], 128'hF01);
      chk("newest_nofwd", rd_fwd[1], 1'b0); step();
      idle(); rd_addr[1] = 7'd4; #1 chk("newest_data", rd_data[1], 128'd6); step();
      repeat (DEPTH) begin idle(); step(); end

      // same-stage tie
      idle(); issue(0, 7'd5); issue(1, 7'd5); step();
      idle(); result(0, 3'd1, 128'hA); result(1, 3'd1, 128'hB); step();
      idle(); rd_addr[2] = 7'd5; #1 chk("tie_data", rd_data[2], 128'hB); step();
      repeat (4) begin idle(); step(); end
      idle(); #1 chk("tie_wb_both", wb_valid, 2'b11); chk("tie_wb_data1", wb_data[1], 128'hB); step();

      // flush
      idle(); issue(0, 7'd8); step();
      idle(); result(0, 3'd1, 128'h55); step();
      idle(); issue(0, 7'd9); step();
      idle(); step();
      idle(); issue(0, 7'd10); step();
      idle(); flush_valid = 1'b1; flush_stage = 3'd4; issue(0, 7'd11); step();
      idle(); rd_addr[0] = 7'd9; rd_addr[1] = 7'd10; rd_addr[2] = 7'd11; rd_addr[3] = 7'd8;
      #1 chk("flush_fwd", rd_fwd, 5'b01000); chk("flush_stall", stall, 1'b0); step();
      idle(); #1 chk("flush_wb_valid", wb_valid[0], 1'b1); chk("flush_wb_addr", wb_addr[0], 7'd8); step();

      // hold with a ready entry parked at the last stage
      idle(); issue(1, 7'd14); step();
      idle(); result(1, 3'd1, 128'h14); step();
      repeat (4) begin idle(); step(); end
      idle(); issue(0, 7'd12); step();
      for (int k = 0; k < 3; k++) begin
         idle(); hold = 1'b1; issue(1, 7'd13); rd_addr[0] = 7'd12; rd_addr[1] = 7'd13;
         if (k == 0) result(0, 3'd1, 128'h77);
         #1 chk("hold_wb_off", wb_valid, 2'b00);
         if (k > 0) chk("hold_res_fwd", rd_data[0], 128'h77);
         step();
      end
      idle(); rd_addr[1] = 7'd13;
      #1 chk("hold_rel_wb", wb_valid[1], 1'b1); chk("hold_rel_addr", wb_addr[1], 7'd14);
      chk("hold_no_issue", rd_fwd[1], 1'b0); step();

      // late result
      idle(); issue(1, 7'd15); step();
      repeat (DEPTH - 1) begin idle(); step(); end
      idle(); #1 chk("late_before", err_late, 1'b0); step();
      idle(); #1 chk("late_set", err_late, 1'b1); step();
      repeat (2) begin idle(); step(); end
      idle(); #1 chk("late_sticky", err_late, 1'b1); issue(0, 7'd16); step();

      // reset mid-run
      idle(); do_reset();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         idle();
         if (c % 150 == 149) begin
            do_reset();
         end else begin
            hold = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < NP; p++) begin
               issue_valid[p] = 1'($urandom_range(0, 1));
               issue_rt[p]    = AW'($urandom_range(0, 7));
               res_valid[p]   = ($urandom_range(0, 2) != 0);
               res_stage[p]   = SW'($urandom_range(0, DEPTH));
               res_data[p]    = {$urandom, $urandom, $urandom, $urandom};
            end
            flush_valid = ($urandom_range(0, 19) == 0);
            flush_stage = SW'($urandom_range(1, DEPTH));
            for (int r = 0; r < NR; r++) begin
               rd_addr[r]    = AW'($urandom_range(0, 7));
               rd_rf_data[r] = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
         end
      end

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
